// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder slice plus a carry flip-flop, LSB first,
// with a start/busy/done handshake. Define SERIAL_ADDER_OVF_EN to add the ovf output.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   assign o_s  = i_a ^ i_b ^ i_ci;
   assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
endmodule

module serial_adder #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic         ovf
`endif
);
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         r_state;
   logic [W-1:0]   r_sra;
   logic [W-1:0]   r_srb;
   logic [W-1:0]   r_sacc;
   logic           r_cff;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;
   logic           r_done;
   logic [W-1:0]   r_sum;
   logic           r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic           r_ovf;
`endif

   logic           w_s;
   logic           w_c;
   logic [W-1:0]   w_sacc_next;

   full_adder u_slice (
      .i_a  (r_sra[0]),
      .i_b  (r_srb[0]),
      .i_ci (r_cff),
      .o_s  (w_s),
      .o_co (w_c)
   );

   // The new sum bit enters at the top so bit 0 ends up at sacc[0] after W shifts.
   generate
      if (W == 1) begin : g_w1
         assign w_sacc_next = w_s;
      end else begin : g_wn
         assign w_sacc_next = {w_s, r_sacc[W-1:1]};
      end
   endgenerate

   // NOTE: every register here uses <= so all of them sample pre-edge values;
   // blocking assignments would let the shift and the carry see each other's new values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sra   <= '0;
         r_srb   <= '0;
         r_sacc  <= '0;
         r_cff   <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_sra   <= a;
                  r_srb   <= b;
                  r_cff   <= cin;
                  r_cnt   <= '0;
                  r_sacc  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_sra  <= r_sra >> 1;
               r_srb  <= r_srb >> 1;
               r_sacc <= w_sacc_next;
               r_cff  <= w_c;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_sum   <= w_sacc_next;
                  r_cout  <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                  // r_cff is the carry into bit W-1 on this edge.
                  r_ovf   <= r_cff ^ w_c;
`endif
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8 and W=1 instances) against an
// arithmetic reference model; honours SERIAL_ADDER_OVF_EN.

module tb_serial_adder;
   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   logic       s1_start;
   logic [0:0] s1_a;
   logic [0:0] s1_b;
   logic       s1_cin;
   logic       s1_busy;
   logic       s1_done;
   logic [0:0] s1_sum;
   logic       s1_cout;
   logic       s1_ovf;

   int n_checks = 0;
   int n_pass   = 0;

   serial_adder #(.W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
     ,.ovf   (ovf)
`endif
   );

   serial_adder #(.W(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (s1_start),
      .a     (s1_a),
      .b     (s1_b),
      .cin   (s1_cin),
      .busy  (s1_busy),
      .done  (s1_done),
      .sum   (s1_sum),
      .cout  (s1_cout)
`ifdef SERIAL_ADDER_OVF_EN
     ,.ovf   (s1_ovf)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf    = 1'b0;
   assign s1_ovf = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic, signed overflow from range of the signed sum.
   task automatic model8(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                         output logic [7:0] es, output logic ec, output logic eo);
      int u;
      int ss;
      int ia;
      int ib;
      u  = int'(ma) + int'(mb) + int'(mc);
      ia = int'($signed(ma));
      ib = int'($signed(mb));
      ss = ia + ib + int'(mc);
      es = u[7:0];
      ec = (u > 255);
      eo = (ss > 127) || (ss < -128);
   endtask

   task automatic wait_done(input bit disturb, output int cycles, output int busy_n,
                            output bit stable);
      logic [7:0] s0;
      s0 = sum;
      cycles = 0;
      busy_n = 0;
      stable = 1'b1;
      while (cycles < 40) begin
         @(negedge clk);
         cycles++;
         if (done) break;
         if (busy) busy_n++;
         if (sum !== s0) stable = 1'b0;
         if (disturb && cycles == 3) begin
            start = 1'b1;
            a     = 8'hC3;
            b     = 8'h5A;
            cin   = 1'b0;
         end else if (disturb && cycles == 4) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c,
                        input bit disturb, input string tag);
      logic [7:0] es;
      logic       ec;
      logic       eo;
      int         cyc;
      int         bn;
      bit         st;
      model8(op_a, op_b, op_c, es, ec, eo);
      @(negedge clk);
      a = op_a; b = op_b; cin = op_c; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(disturb, cyc, bn, st);
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_latency"}, 32'(cyc - 1), 32'd8);
      check({tag, "_busy_cycles"}, 32'(bn), 32'd8);
      check({tag, "_sum_held_in_run"}, 32'(st), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int         cyc;
      int         bn;
      bit         st;
      int         seen;
      logic [1:0] t1;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);

      do_op(8'h3C, 8'h5A, 1'b0, 1'b0, "op_3c_5a");
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, "op_ff_01");
      do_op(8'h7F, 8'h01, 1'b0, 1'b0, "op_7f_01");
      do_op(8'h00, 8'h00, 1'b1, 1'b1, "op_cin_disturbed");
      check("disturbed_sum_is_01", 32'(sum), 32'h01);

      // Asynchronous reset mid-cycle: outputs clear before the next edge.
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_sum", 32'(sum), 32'd0);
      check("async_rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Start held high: back-to-back operations, done pulses 9 cycles apart.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 a = 8'h01; b = 8'h02;
      wait_done(1'b0, cyc, bn, st);
      check("held_first_done", 32'(done), 32'd1);
      check("held_first_sum", 32'(sum), 32'h30);
      wait_done(1'b0, cyc, bn, st);
      start = 1'b0;
      check("held_second_done", 32'(done), 32'd1);
      check("held_gap", 32'(cyc), 32'd9);
      check("held_second_busy_cycles", 32'(bn), 32'd8);
      check("held_second_sum", 32'(sum), 32'h03);
      @(negedge clk);
      check("held_done_drops", 32'(done), 32'd0);
      check("held_idle", 32'(busy), 32'd0);

      // Reset at RUN cycle 4 aborts the operation with no done pulse.
      @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("midrun_busy_before_rst", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrun_rst_busy", 32'(busy), 32'd0);
      check("midrun_rst_sum", 32'(sum), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("midrun_no_done", 32'(seen), 32'd0);
      check("midrun_sum_zero", 32'(sum), 32'd0);
      do_op(8'hAA, 8'h55, 1'b0, 1'b0, "op_aa_55_after_rst");

      for (int i = 0; i < 30; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
      end

      // W=1 instance: 1+1+1 = 3 -> sum 1, cout 1, one RUN cycle.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin
            s1_a = 1'b1; s1_b = 1'b1; s1_cin = 1'b1;
         end else begin
            s1_a = 1'($urandom); s1_b = 1'($urandom); s1_cin = 1'($urandom);
         end
         t1 = 2'(s1_a) + 2'(s1_b) + 2'(s1_cin);
         s1_start = 1'b1;
         @(posedge clk);
         #1 s1_start = 1'b0;
         @(negedge clk);
         check("w1_busy_in_run", 32'(s1_busy), 32'd1);
         check("w1_no_early_done", 32'(s1_done), 32'd0);
         @(negedge clk);
         check("w1_done", 32'(s1_done), 32'd1);
         check("w1_sum", 32'(s1_sum), 32'(t1[0]));
         check("w1_cout", 32'(s1_cout), 32'(t1[1]));
`ifdef SERIAL_ADDER_OVF_EN
         check("w1_ovf", 32'(s1_ovf), 32'(s1_cin ^ t1[1]));
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
